// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The HI/LO select encoding matches the datapath hi_lo control.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_ITER  = 32;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide unit bundle: issue, mthi/mtlo, mfhi/mflo and status.
interface mdu_sequencer_if #(
    parameter int unsigned WIDTH = mdu_pkg::MDU_WIDTH
);

    logic             start_mul;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mt_we;
    logic             mt_sel;
    logic [WIDTH-1:0] mt_data;
    logic             mf_req;
    logic             mf_sel;
    logic             flush;
    logic [WIDTH-1:0] mf_data;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mul, start_div, op_a, op_b, mt_we, mt_sel, mt_data, mf_req, mf_sel, flush,
        input  mf_data, stall, busy, done, hi, lo
    );

    modport slave (
        input  start_mul, start_div, op_a, op_b, mt_we, mt_sel, mt_data, mf_req, mf_sel, flush,
        output mf_data, stall, busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// Accumulator layout is {rem/hi (WIDTH+1), quotient/lo (WIDTH)} in both modes.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  state_e             mode_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        shifted = {acc_i[2*WIDTH:WIDTH], acc_i[WIDTH-1]};
        diff    = shifted - {2'b00, operand_i};
        acc_o   = acc_i;
        case (mode_i)
            // Multiplier sits in the low half and shifts out as product bits shift in.
            MUL: acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
            // Borrow out of diff means the trial subtraction fails: restore.
            DIV: acc_o = diff[WIDTH+1] ? {shifted[WIDTH:0], acc_i[WIDTH-2:0], 1'b0}
                                       : {diff[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO owner for the pipeline: sequences multu/divu one bit per cycle, handles
// mthi/mtlo, serves mfhi/mflo combinationally and stalls accesses while busy.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned ITER  = MDU_ITER
) (
    input logic            Clk,
    input logic            reset_n,
    mdu_sequencer_if.slave bus
);

    localparam int unsigned AccW = 2 * WIDTH + 1;
    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [AccW-1:0]   acc_step;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic              busy;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i    (state_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (acc_step)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.flush) begin
                    // A start overrides a same-cycle mt write: the result rewrites both halves.
                    if (bus.start_mul) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = {{(WIDTH + 1){1'b0}}, bus.op_b};
                        opnd_d  = bus.op_a;
                    end else if (bus.start_div) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        acc_d   = {{(WIDTH + 1){1'b0}}, bus.op_a};
                        opnd_d  = bus.op_b;
                    end else if (bus.mt_we) begin
                        if (bus.mt_sel == SEL_HI) hi_d = bus.mt_data;
                        else                      lo_d = bus.mt_data;
                    end
                end
            end
            MUL, DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(ITER - 1)) begin
                        // Product and {remainder, quotient} share the same slice positions.
                        hi_d    = acc_step[2*WIDTH-1:WIDTH];
                        lo_d    = acc_step[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.stall   = busy & (bus.start_mul | bus.start_div | bus.mf_req | bus.mt_we);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = (bus.mf_sel == SEL_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: expected {HI,LO} results are queued at issue
// and compared when done pulses; timing, stall, flush and reset behaviour checked inline.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [63:0] exp_q[$];

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .Clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit is_div, input logic [31:0] a,
                                          input logic [31:0] b);
        if (!is_div)     return 64'(a) * 64'(b);
        else if (b == 0) return {a, 32'hFFFF_FFFF};
        else             return {a % b, a / b};
    endfunction

    // Result scoreboard: every done pulse must match the oldest outstanding issue.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                check("result", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    // Called at the negedge after the accept edge.
    task automatic wait_commit(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 64'(n), 64'd32);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        @(negedge clk);
        check({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input bit both, input bit with_mt);
        @(negedge clk);
        bus.start_mul = !is_div;
        bus.start_div = is_div | both;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.mt_we     = with_mt;
        bus.mt_sel    = SEL_LO;
        bus.mt_data   = 32'h55;
        exp_q.push_back(model(is_div, a, b));
        @(negedge clk);
        bus.start_mul = 1'b0;
        bus.start_div = 1'b0;
        bus.mt_we     = 1'b0;
        wait_commit(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dones;
        rst_n         = 1'b0;
        bus.start_mul = 1'b0;
        bus.start_div = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.mt_we     = 1'b0;
        bus.mt_sel    = 1'b0;
        bus.mt_data   = '0;
        bus.mf_req    = 1'b0;
        bus.mf_sel    = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);

        // Both starts high: multiply wins.
        run_op("mul_small", 1'b0, 32'h1e, 32'h1f, 1'b1, 1'b0);
        // Same-cycle mtlo is dropped in favour of the start.
        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("div_by0", 1'b1, 32'h1234, 32'd0, 1'b0, 1'b0);

        // mflo plus a held divu one cycle after a multu accept.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.op_a      = 32'd6;
        bus.op_b      = 32'd7;
        exp_q.push_back(model(1'b0, 32'd6, 32'd7));
        @(negedge clk);
        bus.start_mul = 1'b0;
        @(negedge clk);
        bus.mf_req    = 1'b1;
        bus.mf_sel    = SEL_LO;
        bus.start_div = 1'b1;
        bus.op_a      = 32'd1000;
        bus.op_b      = 32'd33;
        exp_q.push_back(model(1'b1, 32'd1000, 32'd33));
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_len", 64'(n), 64'd31);
        check("stall_mf_data", 64'(bus.mf_data), 64'd42);
        check("stall_done", 64'(bus.done), 64'd1);
        @(negedge clk);
        bus.start_div = 1'b0;
        bus.mf_req    = 1'b0;
        check("held_div_accept", 64'(bus.busy), 64'd1);
        wait_commit("held_div");

        // mthi/mtlo in IDLE, then IDLE mfhi/mflo with no stall.
        @(negedge clk);
        bus.mt_we   = 1'b1;
        bus.mt_sel  = SEL_HI;
        bus.mt_data = 32'hDEAD;
        @(negedge clk);
        bus.mt_sel  = SEL_LO;
        bus.mt_data = 32'h0;
        @(negedge clk);
        bus.mt_we   = 1'b0;
        check("mt_hilo", {bus.hi, bus.lo}, {32'hDEAD, 32'h0});
        bus.mf_req = 1'b1;
        bus.mf_sel = SEL_HI;
        #1;
        check("mf_idle_hi", 64'(bus.mf_data), 64'hDEAD);
        check("mf_idle_stall", 64'(bus.stall), 64'd0);
        bus.mf_req = 1'b0;

        // multu 3x5 flushed at cycle 10.
        @(negedge clk);
        bus.start_mul = 1'b1;
        bus.op_a      = 32'd3;
        bus.op_b      = 32'd5;
        @(negedge clk);
        bus.start_mul = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_pre_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {32'hDEAD, 32'h0});
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);

        // Flush in IDLE masks start and mt write.
        bus.flush     = 1'b1;
        bus.start_mul = 1'b1;
        bus.mt_we     = 1'b1;
        bus.mt_sel    = SEL_HI;
        bus.mt_data   = 32'h5;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.start_mul = 1'b0;
        bus.mt_we     = 1'b0;
        check("idle_flush_busy", 64'(bus.busy), 64'd0);
        check("idle_flush_hi", 64'(bus.hi), 64'hDEAD);

        // Async reset in the middle of a divide.
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.op_a      = 32'h1234;
        bus.op_b      = 32'd7;
        @(negedge clk);
        bus.start_div = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_mul", 1'b0, 32'd2, 32'd2, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Iterative unsigned multiply/divide controller that owns the HI/LO register pair for the pipelined MIPS core. It replaces the single-cycle multu/HI-LO path in the datapath. The EX stage issues multu/divu/mthi/mtlo to it, and mfhi/mflo read from it. It stalls the pipeline whenever an access would observe an incomplete result.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, 32, iterations per operation (must equal WIDTH)

Ports:
Clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start_mul  in  1  EX-stage multu issue
start_div  in  1  EX-stage divu issue
op_a  in  WIDTH  rs operand (multiplicand / dividend)
op_b  in  WIDTH  rt operand (multiplier / divisor)
mt_we  in  1  mthi/mtlo write request
mt_sel  in  1  0=LO, 1=HI (mt and mf share encoding with datapath hi_lo)
mt_data  in  WIDTH  mthi/mtlo data
mf_req  in  1  mfhi/mflo in EX
mf_sel  in  1  0=LO, 1=HI
flush  in  1  abort in-flight operation (branch/jump squash)
mf_data  out  WIDTH  combinational: mf_sel ? HI : LO
stall  out  1  hold IF/ID/EX, bubble MEM
busy  out  1  iteration in progress
done  out  1  one-cycle pulse, result committed
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset_n=0, async): state=IDLE, hi=lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation discards all partial state immediately.
- States: IDLE, MUL, DIV.
- IDLE, accept edge:
  - start_mul=1: latch op_a/op_b, clear accumulator, counter=0, go to MUL.
  - else start_div=1: latch op_a/op_b, clear accumulator, counter=0, go to DIV.
  - If start_mul and start_div are both high, multiply wins; divide is ignored.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 64-bit product.
- DIV: restoring division, one quotient bit per cycle. Remainder is WIDTH+1 bits wide to hold the carry.
- Iteration k occurs at edge k after accept (k=1..ITER).
- Commit at edge ITER:
  - MUL: HI=product[63:32], LO=product[31:0].
  - DIV: LO=quotient, HI=remainder.
  - Then state returns to IDLE.
- busy=1 for exactly ITER cycles (from after the accept edge through the commit edge).
- done=1 for the single cycle following the commit edge.
- Divide by zero needs no special case; restoring behaviour gives LO=0xFFFFFFFF, HI=dividend.
- stall = busy & (start_mul | start_div | mf_req | mt_we).
  - Stalled requests are not consumed; the requester holds them, and they are accepted on the first cycle busy=0.
  - A stall never occurs in IDLE, so mf_req in IDLE returns the current HI/LO the same cycle.
- mt_we in IDLE writes the selected register at the edge.
  - Same-cycle mt_we with start_*: the start wins, because the result will overwrite both registers; mt_we is dropped.
- flush while busy: return to IDLE at the next edge, hi/lo unchanged, no done pulse.
- flush in IDLE masks start_*/mt_we for that cycle.
- A new start in the done cycle is legal (back-to-back, 1 idle cycle).
- All arithmetic is unsigned; no signed mult/div support.

Decomposition:
- Shared package mdu_pkg holds:
  - state enum {IDLE, MUL, DIV}
  - MDU_WIDTH=32, MDU_ITER=32
  - HI/LO select encoding constants (SEL_LO=0, SEL_HI=1), shared with the datapath hi_lo control.
- One sub-module, mdu_step: combinational single-iteration unit.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator/shift state.
- mdu_sequencer holds the FSM, counter, HI/LO and stall logic.

Test Plan:
- multu 0x1e × 0x1f in IDLE -> busy high for 32 cycles; done pulses once; LO=0x3a2, HI=0.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- divu 100 / 7 -> LO=14, HI=2. divu 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234.
- mflo asserted 1 cycle after multu 6×7 accept:
  - stall=1 for 31 cycles, deasserts the cycle after commit.
  - mf_data=42 when stall drops.
  - A held divu start is accepted on that same first non-busy cycle.
- mthi 0xDEAD then multu 3×5, with flush at cycle 10 of the multiply -> IDLE next edge, HI=0xDEAD, LO=0, no done pulse.
- reset_n low for one cycle at cycle 10 of a divu -> busy=0, hi=lo=0 immediately; a subsequent multu 2×2 completes normally with LO=4.
